// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: accepts commands, drives an external combinational
// ALU, captures its response and returns it over a valid/ready handshake.
module alu_cmd_issuer #(
  parameter int OP_WIDTH  = 4,
  parameter int RES_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_WIDTH-1:0]  cmd_op1,
  input  logic [OP_WIDTH-1:0]  cmd_op2,
  input  logic [2:0]           cmd_opcode,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_corr,
`ifdef TAINT
  input  logic                 cmd_op1_t,
  input  logic                 cmd_op2_t,
  input  logic                 cmd_opcode_t,
  input  logic                 cfg_corr_t,
  output logic                 alu_op1_t,
  output logic                 alu_op2_t,
  output logic                 alu_opcode_t,
  output logic                 alu_ops_correlated_t,
  input  logic                 alu_result_t,
  input  logic                 alu_exception_t,
  output logic                 rsp_result_t,
  output logic                 rsp_exception_t,
`endif
  output logic [OP_WIDTH-1:0]  alu_op1,
  output logic [OP_WIDTH-1:0]  alu_op2,
  output logic [2:0]           alu_opcode,
  output logic [7:0]           alu_ops_correlated,
  input  logic [RES_WIDTH-1:0] alu_result,
  input  logic                 alu_exception,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RES_WIDTH-1:0] rsp_result,
  output logic                 rsp_exception,
  output logic                 rsp_err,
  output logic [7:0]           issued_cnt,
  output logic [7:0]           exc_cnt
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_ISSUE   = 2'b01;
  localparam logic [1:0] S_CAPTURE = 2'b10;
  localparam logic [1:0] S_RESP    = 2'b11;

  localparam logic [2:0] OPC_DIV = 3'b011;

  logic [1:0]           state_q, state_d;
  logic [OP_WIDTH-1:0]  op1_q, op1_d;
  logic [OP_WIDTH-1:0]  op2_q, op2_d;
  logic [2:0]           opc_q, opc_d;
  logic [7:0]           corr_q, corr_d;
  logic [RES_WIDTH-1:0] res_q, res_d;
  logic                 exc_q, exc_d;
  logic                 err_q, err_d;
  logic [7:0]           icnt_q, icnt_d;
  logic [7:0]           ecnt_q, ecnt_d;

  logic st_idle, st_issue, st_capt, st_resp;
  logic accept;

  assign st_idle  = (state_q == S_IDLE);
  assign st_issue = (state_q == S_ISSUE);
  assign st_capt  = (state_q == S_CAPTURE);
  assign st_resp  = (state_q == S_RESP);
  assign accept   = cmd_valid && st_idle;

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    corr_d  = corr_q;
    res_d   = res_q;
    exc_d   = exc_q;
    err_d   = err_q;
    icnt_d  = icnt_q;
    ecnt_d  = ecnt_q;
    if (cfg_we) corr_d = cfg_corr;
    unique case (1'b1)
      st_idle: begin
        if (accept) begin
          if (cmd_opcode == OPC_DIV) begin
            res_d   = '0;
            exc_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            op1_d   = cmd_op1;
            op2_d   = cmd_op2;
            opc_d   = cmd_opcode;
            state_d = S_ISSUE;
          end
        end
      end
      st_issue: begin
        if (icnt_q != 8'hFF) icnt_d = icnt_q + 8'd1;
        state_d = S_CAPTURE;
      end
      st_capt: begin
        res_d = alu_result;
        exc_d = alu_exception;
        err_d = 1'b0;
        if (alu_exception && ecnt_q != 8'hFF)
          ecnt_d = ecnt_q + 8'd1;
        state_d = S_RESP;
      end
      st_resp: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      corr_q  <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      err_q   <= 1'b0;
      icnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      corr_q  <= corr_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      err_q   <= err_d;
      icnt_q  <= icnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

`ifdef TAINT
  logic op1_t_q, op2_t_q, opc_t_q, corr_t_q;
  logic res_t_q, exc_t_q;
  logic op1_t_d, op2_t_d, opc_t_d, corr_t_d;
  logic res_t_d, exc_t_d;

  always_comb begin
    op1_t_d  = op1_t_q;
    op2_t_d  = op2_t_q;
    opc_t_d  = opc_t_q;
    corr_t_d = corr_t_q;
    res_t_d  = res_t_q;
    exc_t_d  = exc_t_q;
    if (cfg_we) corr_t_d = cfg_corr_t;
    if (accept && cmd_opcode != OPC_DIV) begin
      op1_t_d = cmd_op1_t;
      op2_t_d = cmd_op2_t;
      opc_t_d = cmd_opcode_t;
    end
    if (accept && cmd_opcode == OPC_DIV) begin
      res_t_d = 1'b0;
      exc_t_d = 1'b0;
    end
    if (st_capt) begin
      res_t_d = alu_result_t;
      exc_t_d = alu_exception_t;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1_t_q  <= 1'b0;
      op2_t_q  <= 1'b0;
      opc_t_q  <= 1'b0;
      corr_t_q <= 1'b0;
      res_t_q  <= 1'b0;
      exc_t_q  <= 1'b0;
    end else begin
      op1_t_q  <= op1_t_d;
      op2_t_q  <= op2_t_d;
      opc_t_q  <= opc_t_d;
      corr_t_q <= corr_t_d;
      res_t_q  <= res_t_d;
      exc_t_q  <= exc_t_d;
    end
  end

  assign alu_op1_t            = op1_t_q;
  assign alu_op2_t            = op2_t_q;
  assign alu_opcode_t         = opc_t_q;
  assign alu_ops_correlated_t = corr_t_q;
  assign rsp_result_t         = res_t_q;
  assign rsp_exception_t      = exc_t_q;
`endif

  assign cmd_ready          = st_idle;
  assign rsp_valid          = st_resp;
  assign alu_op1            = op1_q;
  assign alu_op2            = op2_q;
  assign alu_opcode         = opc_q;
  assign alu_ops_correlated = corr_q;
  assign rsp_result         = res_q;
  assign rsp_exception      = exc_q;
  assign rsp_err            = err_q;
  assign issued_cnt         = icnt_q;
  assign exc_cnt            = ecnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU model.
// Each comparison is an immediate assertion counted in n_assert/n_fail.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op1, cmd_op2;
  logic [2:0] cmd_opcode;
  logic       cfg_we;
  logic [7:0] cfg_corr;
  logic [3:0] alu_op1, alu_op2;
  logic [2:0] alu_opcode;
  logic [7:0] alu_ops_correlated;
  logic [7:0] alu_result;
  logic       alu_exception;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_exception, rsp_err;
  logic [7:0] issued_cnt, exc_cnt;
  logic       force_exc;

`ifdef TAINT
  logic cmd_op1_t, cmd_op2_t, cmd_opcode_t, cfg_corr_t;
  logic alu_op1_t, alu_op2_t, alu_opcode_t;
  logic alu_ops_correlated_t;
  logic alu_result_t, alu_exception_t;
  logic rsp_result_t, rsp_exception_t;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.OP_WIDTH(4), .RES_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .cmd_opcode(cmd_opcode),
    .cfg_we(cfg_we), .cfg_corr(cfg_corr),
`ifdef TAINT
    .cmd_op1_t(cmd_op1_t), .cmd_op2_t(cmd_op2_t),
    .cmd_opcode_t(cmd_opcode_t),
    .cfg_corr_t(cfg_corr_t),
    .alu_op1_t(alu_op1_t), .alu_op2_t(alu_op2_t),
    .alu_opcode_t(alu_opcode_t),
    .alu_ops_correlated_t(alu_ops_correlated_t),
    .alu_result_t(alu_result_t),
    .alu_exception_t(alu_exception_t),
    .rsp_result_t(rsp_result_t),
    .rsp_exception_t(rsp_exception_t),
`endif
    .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_opcode(alu_opcode),
    .alu_ops_correlated(alu_ops_correlated),
    .alu_result(alu_result),
    .alu_exception(alu_exception),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_exception(rsp_exception),
    .rsp_err(rsp_err),
    .issued_cnt(issued_cnt), .exc_cnt(exc_cnt)
  );

  // Behavioural combinational ALU
  always_comb begin
    logic [7:0] a, b;
    a = {4'b0, alu_op1};
    b = {4'b0, alu_op2};
    case (alu_opcode)
      3'd0:    alu_result = a + b;
      3'd1:    alu_result = a - b;
      3'd2:    alu_result = a * b;
      3'd4:    alu_result = a << alu_op2;
      3'd5:    alu_result = a >> alu_op2;
      default: alu_result = 8'h00;
    endcase
    alu_exception = force_exc;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] a,
                         input logic [3:0] b,
                         input logic [2:0] o,
                         output int l);
    @(negedge clk);
    cmd_op1    = a;
    cmd_op2    = b;
    cmd_opcode = o;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    l = 1;
    while (!rsp_valid && l < 8) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 0; cmd_op1 = 0; cmd_op2 = 0;
    cmd_opcode = 0; cfg_we = 0; cfg_corr = 0;
    rsp_ready = 0; force_exc = 0;
`ifdef TAINT
    cmd_op1_t = 0; cmd_op2_t = 0;
    cmd_opcode_t = 0; cfg_corr_t = 0;
    alu_result_t = 0; alu_exception_t = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_alu_op1", alu_op1, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_issued", issued_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // ADD 3+4
    run_cmd(4'd3, 4'd4, 3'd0, lat);
    check("add_lat", lat, 3);
    check("add_res", rsp_result, 8'h07);
    check("add_err", rsp_err, 0);
    check("add_issued", issued_cnt, 1);
    ack();
    check("add_idle", cmd_ready, 1);

    // MUL 15*15 with backpressure
    run_cmd(4'd15, 4'd15, 3'd2, lat);
    check("mul_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      check("mul_hold_res", rsp_result, 8'hE1);
      check("mul_hold_valid", rsp_valid, 1);
      check("mul_hold_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    cmd_op1 = 4'd1; cmd_op2 = 4'd1;
    cmd_opcode = 3'd0; cmd_valid = 1'b1;
    ack();
    cmd_valid = 1'b0;
    check("mul_idle", cmd_ready, 1);
    check("mul_no_reaccept", rsp_valid, 0);
    check("mul_alu_op1", alu_op1, 15);

    // DIV rejection
    run_cmd(4'd8, 4'd0, 3'd3, lat);
    check("div_lat", lat, 1);
    check("div_err", rsp_err, 1);
    check("div_res", rsp_result, 0);
    check("div_issued", issued_cnt, 2);
    check("div_alu_op1", alu_op1, 15);
    check("div_alu_opc", alu_opcode, 2);
    ack();

    // cfg write in IDLE, then during ISSUE
    @(negedge clk);
    cfg_we = 1'b1; cfg_corr = 8'hA5;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_idle", alu_ops_correlated, 8'hA5);
    cmd_op1 = 4'd7; cmd_op2 = 4'd3;
    cmd_opcode = 3'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cfg_we = 1'b1; cfg_corr = 8'h5A;
    check("sub_issue_op1", alu_op1, 7);
    check("cfg_before", alu_ops_correlated, 8'hA5);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cfg_after", alu_ops_correlated, 8'h5A);
    check("cfg_capt_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    check("sub_valid", rsp_valid, 1);
    check("sub_res", rsp_result, 8'h04);
    ack();

    // reset during CAPTURE of SUB 5-2
    @(negedge clk);
    cmd_op1 = 4'd5; cmd_op2 = 4'd2;
    cmd_opcode = 3'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mrst_valid", rsp_valid, 0);
    check("mrst_ready", cmd_ready, 1);
    check("mrst_alu_op1", alu_op1, 0);
    check("mrst_alu_opc", alu_opcode, 0);
    check("mrst_corr", alu_ops_correlated, 0);
    check("mrst_issued", issued_cnt, 0);
    check("mrst_res", rsp_result, 0);
    @(posedge clk);
    #1;
    check("mrst_valid2", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_no_rsp", rsp_valid, 0);
    run_cmd(4'd2, 4'd9, 3'd0, lat);
    check("post_add_lat", lat, 3);
    check("post_add_res", rsp_result, 8'h0B);
    check("post_add_issued", issued_cnt, 1);
    ack();

    // counter saturation with forced exceptions
    force_exc = 1'b1;
    for (int i = 0; i < 254; i++) begin
      run_cmd(4'd1, 4'd3, 3'd4, lat);
      ack();
    end
    check("sat_issued_mid", issued_cnt, 255);
    check("sat_exc_mid", exc_cnt, 254);
    for (int i = 0; i < 2; i++) begin
      run_cmd(4'd1, 4'd3, 3'd4, lat);
      ack();
    end
    check("sll_res", rsp_result, 8'h08);
    check("sll_exc", rsp_exception, 1);
    check("sat_issued", issued_cnt, 255);
    check("sat_exc", exc_cnt, 255);
    force_exc = 1'b0;

`ifdef TAINT
    @(negedge clk);
    cmd_op1_t = 1'b1; cmd_op2_t = 1'b0;
    alu_result_t = 1'b1;
    cmd_op1 = 4'd1; cmd_op2 = 4'd1;
    cmd_opcode = 3'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("t_op1_issue", alu_op1_t, 1);
    check("t_op2_issue", alu_op2_t, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t_valid", rsp_valid, 1);
    check("t_res", rsp_result_t, 1);
    ack();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter OP_WIDTH, default 4, operand width driven to the ALU.
REQ-002 Parameter RES_WIDTH, default 8, ALU result width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid, cmd_ready  in/out  1 each  upstream command handshake.
REQ-006 cmd_op1, cmd_op2  in  OP_WIDTH each  command operands.
REQ-007 cmd_opcode  in  3  command opcode: ADD=000, SUB=001, MUL=010, DIV=011, SLL=100, SRL=101, SLA=110, SRA=111.
REQ-008 cfg_we  in  1, cfg_corr  in  8  write strobe and value for the ops_correlated register.
REQ-009 alu_op1, alu_op2  out  OP_WIDTH; alu_opcode  out  3; alu_ops_correlated  out  8  drive to the ALU.
REQ-010 alu_result  in  RES_WIDTH; alu_exception  in  1  combinational ALU response.
REQ-011 rsp_valid, rsp_ready  out/in  1 each  downstream response handshake.
REQ-012 rsp_result  out  RES_WIDTH; rsp_exception  out  1; rsp_err  out  1  (unsupported opcode).
REQ-013 issued_cnt, exc_cnt  out  8 each  saturating counters.
REQ-014 Taint ports, present only when TAINT is defined: cmd_op1_t, cmd_op2_t, cmd_opcode_t, cfg_corr_t in 1; alu_op1_t, alu_op2_t, alu_opcode_t, alu_ops_correlated_t out 1; alu_result_t, alu_exception_t in 1; rsp_result_t, rsp_exception_t out 1.

Function
REQ-015 FSM states: IDLE, ISSUE, CAPTURE, RESP; IDLE after reset.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-017 On accept with opcode != DIV: latch op1/op2/opcode (and taints) into the alu_* drive registers, go to ISSUE.
REQ-018 On accept with opcode == DIV: do not drive the ALU; load rsp_err=1, rsp_result=0, rsp_exception=0, go directly to RESP; issued_cnt unchanged.
REQ-019 ISSUE lasts exactly one cycle (ALU settling), then CAPTURE.
REQ-020 CAPTURE lasts exactly one cycle: register alu_result, alu_exception (and taints) into rsp_*, rsp_err=0, go to RESP.
REQ-021 Latency accept-to-rsp_valid: 3 cycles for supported opcodes, 1 cycle for DIV.
REQ-022 In RESP rsp_valid=1 and rsp_* SHALL hold stable until rsp_valid && rsp_ready, then IDLE; no new command accepted in the same cycle.
REQ-023 alu_op1/op2/opcode SHALL hold their last issued values outside ISSUE/CAPTURE (no glitching to 0).
REQ-024 alu_ops_correlated SHALL be a register written from cfg_corr on cfg_we in any state; a write during ISSUE or CAPTURE takes effect the next cycle and does not abort the operation.
REQ-025 issued_cnt increments by 1 on entry to CAPTURE; exc_cnt increments when CAPTURE captures alu_exception=1; both saturate at 255.
REQ-026 Taint: alu_*_t registered with their data; rsp_result_t = alu_result_t and rsp_exception_t = alu_exception_t sampled in CAPTURE; rsp_*_t = 0 for DIV rejection; alu_ops_correlated_t updated with cfg_corr_t on cfg_we.

Reset
REQ-027 Asserting rst (low) at any time, including mid-operation, SHALL immediately force IDLE, cmd_ready=1 after release, rsp_valid=0.
REQ-028 Reset values: all alu_*, rsp_*, counters, alu_ops_correlated and all taint outputs = 0.
REQ-029 An in-flight command at reset is discarded; no response is produced for it.

Verification
REQ-030 ADD op1=3, op2=4, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_result=8'h07, rsp_err=0, issued_cnt=1.
REQ-031 MUL op1=15, op2=15 with rsp_ready=0 for 5 cycles -> rsp_result=8'hE1 held stable, cmd_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-032 DIV op1=8, op2=0 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0, issued_cnt unchanged, ALU drive unchanged.
REQ-033 256 back-to-back SLL commands with alu_exception forced 1 -> issued_cnt=255, exc_cnt=255 (saturated).
REQ-034 rst low during CAPTURE of SUB 5-2 -> rsp_valid stays 0, all outputs 0, next command processed normally.
REQ-035 TAINT build: ADD with cmd_op1_t=1, cmd_op2_t=0 and ALU returning alu_result_t=1 -> alu_op1_t=1 during ISSUE, rsp_result_t=1 in RESP.
